// File: rtl/color_seq_pkg.sv
// rtl/color_seq_pkg.sv - shared encodings and step table for the color FSM sequencer
package color_seq_pkg;

   localparam logic [1:0] BLUE     = 2'd0;
   localparam logic [1:0] RED      = 2'd1;
   localparam logic [1:0] HSV_IDLE = 2'd2;
   localparam logic [1:0] INVALID  = 2'd3;
   localparam logic [1:0] CMD_NOP  = 2'h3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WALK  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } seq_state_t;

   // One hop toward tgt; returns {cmd, next shadow}. No hop available -> {NOP, cur}.
   function automatic logic [3:0] next_step(input logic [1:0] cur, input logic [1:0] tgt);
      logic [3:0] r;
      r = {CMD_NOP, cur};
      case (cur)
         BLUE: begin
            if (tgt == RED || tgt == HSV_IDLE) r = {2'd1, RED};
         end
         RED: begin
            if (tgt == BLUE)          r = {2'd1, BLUE};
            else if (tgt == HSV_IDLE) r = {2'd2, HSV_IDLE};
         end
         HSV_IDLE: begin
            if (tgt == RED || tgt == BLUE) r = {2'd0, RED};
         end
         default: r = {CMD_NOP, cur};
      endcase
      return r;
   endfunction

endpackage

// File: rtl/color_rr_arbiter.sv
// rtl/color_rr_arbiter.sv - one-hot round-robin grant starting at a pointer
module color_rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    gnt_id_o,
   output logic               any_o
);

   logic [ID_W-1:0] idx;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      any_o    = 1'b0;
      idx      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!any_o && valid_i[idx]) begin
            any_o      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end

endmodule

// File: rtl/color_fsm_sequencer.sv
// rtl/color_fsm_sequencer.sv - arbitrates target requests and walks the Color/HSV FSM there.
// Define COLOR_SEQ_FB_CHECK_EN to verify fb_out after every step.
module color_fsm_sequencer
   import color_seq_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [2*NUM_REQ-1:0] req_target,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [1:0]           cmd,
   input  logic [1:0]           fb_out,
   output logic                 busy,
   output logic                 done,
   output logic [ID_W-1:0]      done_id,
   output logic [1:0]           cur_state,
   output logic                 err,
   input  logic                 err_clr
);

   seq_state_t      state_q, state_d;
   logic [1:0]      cur_q, cur_d;
   logic [1:0]      tgt_q, tgt_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            err_q, err_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_any;
   logic [1:0]         gnt_tgt;
   logic [3:0]         step;

   color_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .valid_i  (req_valid),
      .ptr_i    (ptr_q),
      .gnt_o    (gnt),
      .gnt_id_o (gnt_id),
      .any_o    (gnt_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= RED;
         tgt_q   <= RED;
         id_q    <= '0;
         ptr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         tgt_q   <= tgt_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      gnt_tgt = 2'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) gnt_tgt = req_target[2*i +: 2];
      end
   end

   always_comb begin
      state_d   = state_q;
      cur_d     = cur_q;
      tgt_d     = tgt_q;
      id_d      = id_q;
      ptr_d     = ptr_q;
`ifdef COLOR_SEQ_FB_CHECK_EN
      err_d     = err_q & ~err_clr;
`else
      err_d     = 1'b0;
`endif
      req_ready = '0;
      cmd       = CMD_NOP;
      done      = 1'b0;
      done_id   = '0;
      step      = next_step(cur_q, tgt_q);

      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               req_ready = gnt & {NUM_REQ{~rst}};
               tgt_d     = gnt_tgt;
               id_d      = gnt_id;
               state_d   = WALK;
            end
         end
         WALK: begin
            if (tgt_q == INVALID || cur_q == tgt_q) begin
               state_d = DONE;
            end else begin
               cmd   = step[3:2];
               cur_d = step[1:0];
`ifdef COLOR_SEQ_FB_CHECK_EN
               state_d = CHECK;
`endif
            end
         end
`ifdef COLOR_SEQ_FB_CHECK_EN
         CHECK: begin
            // Controlled FSM moved on the same edge as the shadow, so compare now.
            if (fb_out != ((cur_q == BLUE) ? 2'd1 : 2'd2)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               state_d = WALK;
            end
         end
`endif
         DONE: begin
            done    = 1'b1;
            done_id = id_q;
            ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifndef COLOR_SEQ_FB_CHECK_EN
   logic unused_fb;
   assign unused_fb = ^{fb_out, err_clr};
`endif

   assign busy      = (state_q != IDLE);
   assign cur_state = cur_q;
   assign err       = err_q;

endmodule

// File: tb/tb_color_fsm_sequencer.sv
// tb/tb_color_fsm_sequencer.sv - directed bench with a behavioural model of the controlled FSM
module tb_color_fsm_sequencer;

   localparam int NREQ = 2;
   localparam int IDW  = 1;
`ifdef COLOR_SEQ_FB_CHECK_EN
   localparam int   SC      = 2;
   localparam logic ERR_EXP = 1'b1;
`else
   localparam int   SC      = 1;
   localparam logic ERR_EXP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] req_valid;
   logic [2*NREQ-1:0] req_target;
   logic [NREQ-1:0] req_ready;
   logic [1:0]      cmd;
   logic [1:0]      fb_out;
   logic            busy;
   logic            done;
   logic [IDW-1:0]  done_id;
   logic [1:0]      cur_state;
   logic            err;
   logic            err_clr;

   logic            fb_force;
   logic [1:0]      fb_val;
   logic [1:0]      m_q;

   int total = 0;
   int bad   = 0;

   logic [1:0]      cap_cmd [0:31];
   int              cap_done;
   logic [IDW-1:0]  cap_id;
   logic [NREQ-1:0] cap_rdy;
   logic            cap_busy1;

   always #5 clk = ~clk;

   color_fsm_sequencer #(.NUM_REQ(NREQ), .ID_W(IDW)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_target (req_target),
      .req_ready  (req_ready),
      .cmd        (cmd),
      .fb_out     (fb_out),
      .busy       (busy),
      .done       (done),
      .done_id    (done_id),
      .cur_state  (cur_state),
      .err        (err),
      .err_clr    (err_clr)
   );

   // Controlled Color/HSV machine: 0 Blue, 1 Red, 2 HSV_idle.
   always_ff @(posedge clk) begin
      if (rst) m_q <= 2'd1;
      else begin
         case (m_q)
            2'd0: if (cmd == 2'd1) m_q <= 2'd1;
            2'd1: begin
               if (cmd == 2'd1)      m_q <= 2'd0;
               else if (cmd == 2'd2) m_q <= 2'd2;
            end
            2'd2: if (cmd == 2'd0) m_q <= 2'd1;
            default: m_q <= 2'd1;
         endcase
      end
   end
   assign fb_out = fb_force ? fb_val : ((m_q == 2'd0) ? 2'd1 : 2'd2);

   // Issue one request and record cmd per cycle until done (cycle 0 = accept).
   task automatic request(input int r, input logic [1:0] tgt, input int clr_k);
      logic acc;
      @(posedge clk); #1;
      req_valid = '0;
      req_valid[r] = 1'b1;
      req_target[2*r +: 2] = tgt;
      acc = 1'b0;
      cap_rdy = '0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            acc = 1'b1;
            cap_rdy = req_ready;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      req_valid = '0;
      cap_done = 0;
      for (int k = 1; k < 31; k++) begin
         @(negedge clk);
         cap_cmd[k] = cmd;
         if (k == 1) cap_busy1 = busy;
         err_clr = (k == clr_k);
         if (done) begin
            cap_done = k;
            cap_id = done_id;
            break;
         end
      end
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 2'b11;
      req_target = '0;
      err_clr = 1'b0;
      fb_force = 1'b0;
      fb_val = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      @(negedge clk);
      total++; if (cur_state !== 2'd1) begin bad++; $display("FAIL rst_cur got=%0d exp=1", cur_state); end
      total++; if (cmd !== 2'd3) begin bad++; $display("FAIL rst_cmd got=%0d exp=3", cmd); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
      total++; if ({done, done_id} !== 2'b00) begin bad++; $display("FAIL rst_done got=%b%b exp=00", done, done_id); end
   endtask

   task automatic test_walk(input string name, input int r, input logic [1:0] tgt, input int nsteps,
                            input logic [1:0] c1, input logic [1:0] c2, input logic [1:0] exp_cur);
      logic [NREQ-1:0] erdy;
      logic [1:0] ec;
      erdy = '0;
      erdy[r] = 1'b1;
      request(r, tgt, 0);
      total++; if (cap_rdy !== erdy) begin bad++; $display("FAIL %s ready got=%b exp=%b", name, cap_rdy, erdy); end
      total++; if (cap_done != 2 + nsteps*SC) begin bad++; $display("FAIL %s done_cycle got=%0d exp=%0d", name, cap_done, 2 + nsteps*SC); end
      total++; if (cap_id !== IDW'(r)) begin bad++; $display("FAIL %s done_id got=%0d exp=%0d", name, cap_id, r); end
      total++; if (cur_state !== exp_cur) begin bad++; $display("FAIL %s cur_state got=%0d exp=%0d", name, cur_state, exp_cur); end
      total++; if (cap_busy1 !== 1'b1) begin bad++; $display("FAIL %s busy got=%b exp=1", name, cap_busy1); end
      for (int k = 1; k <= cap_done; k++) begin
         ec = 2'd3;
         if (nsteps >= 1 && k == 1) ec = c1;
         if (nsteps == 2 && k == 1 + SC) ec = c2;
         total++; if (cap_cmd[k] !== ec) begin bad++; $display("FAIL %s cmd[%0d] got=%0d exp=%0d", name, k, cap_cmd[k], ec); end
      end
   endtask

   task automatic test_arb(input int first, input logic [1:0] tgt);
      int second, dc, gc;
      logic [IDW-1:0] did;
      logic [NREQ-1:0] e1, e2, grdy;
      second = 1 - first;
      e1 = '0; e1[first] = 1'b1;
      e2 = '0; e2[second] = 1'b1;
      dc = 0; gc = 0; did = '0; grdy = '0;
      @(posedge clk); #1;
      req_target = {tgt, tgt};
      req_valid = 2'b11;
      @(negedge clk);
      total++; if (req_ready !== e1) begin bad++; $display("FAIL arb_first got=%b exp=%b", req_ready, e1); end
      @(posedge clk); #1;
      req_valid[first] = 1'b0;
      for (int c = 1; c < 20; c++) begin
         @(negedge clk);
         if (done) begin dc = c; did = done_id; end
         if (req_ready != '0) begin gc = c; grdy = req_ready; break; end
      end
      total++; if (dc != 2) begin bad++; $display("FAIL arb_done1 got=%0d exp=2", dc); end
      total++; if (did !== IDW'(first)) begin bad++; $display("FAIL arb_id1 got=%0d exp=%0d", did, first); end
      total++; if (gc != 3) begin bad++; $display("FAIL arb_grant2_cycle got=%0d exp=3", gc); end
      total++; if (grdy !== e2) begin bad++; $display("FAIL arb_grant2 got=%b exp=%b", grdy, e2); end
      @(posedge clk); #1;
      req_valid = '0;
      dc = 0;
      for (int c = 1; c < 20; c++) begin
         @(negedge clk);
         if (done) begin dc = c; did = done_id; break; end
      end
      total++; if (dc != 2) begin bad++; $display("FAIL arb_done2 got=%0d exp=2", dc); end
      total++; if (did !== IDW'(second)) begin bad++; $display("FAIL arb_id2 got=%0d exp=%0d", did, second); end
   endtask

   task automatic test_fb_err();
      fb_force = 1'b1; fb_val = 2'd2;
      request(0, 2'd0, 0);
      fb_force = 1'b0;
      total++; if (cap_done != 3) begin bad++; $display("FAIL fb_done_cycle got=%0d exp=3", cap_done); end
      total++; if (err !== ERR_EXP) begin bad++; $display("FAIL fb_err got=%b exp=%b", err, ERR_EXP); end
      total++; if (cur_state !== 2'd0) begin bad++; $display("FAIL fb_cur got=%0d exp=0", cur_state); end
      total++; if (cap_cmd[1] !== 2'd1) begin bad++; $display("FAIL fb_cmd got=%0d exp=1", cap_cmd[1]); end
      @(posedge clk); #1;
      err_clr = 1'b1;
      @(negedge clk);
      total++; if (err !== ERR_EXP) begin bad++; $display("FAIL clr_hold got=%b exp=%b", err, ERR_EXP); end
      @(posedge clk); #1;
      err_clr = 1'b0;
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL clr_done got=%b exp=0", err); end
      fb_force = 1'b1; fb_val = 2'd1;
      request(0, 2'd1, 2);
      fb_force = 1'b0;
      total++; if (cap_done != 3) begin bad++; $display("FAIL fbclr_done_cycle got=%0d exp=3", cap_done); end
      total++; if (err !== ERR_EXP) begin bad++; $display("FAIL fbclr_err got=%b exp=%b", err, ERR_EXP); end
      total++; if (cur_state !== 2'd1) begin bad++; $display("FAIL fbclr_cur got=%0d exp=1", cur_state); end
   endtask

   task automatic test_mid_reset();
      logic seen;
      @(posedge clk); #1;
      req_valid = 2'b01;
      req_target[1:0] = 2'd2;
      @(negedge clk);
      total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_accept got=%b exp=01", req_ready); end
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      total++; if (cmd !== 2'd1) begin bad++; $display("FAIL mid_step1 got=%0d exp=1", cmd); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
      total++; if (cur_state !== 2'd1) begin bad++; $display("FAIL mid_cur got=%0d exp=1", cur_state); end
      total++; if (cmd !== 2'd3) begin bad++; $display("FAIL mid_cmd got=%0d exp=3", cmd); end
      seen = done;
      repeat (3) begin
         @(negedge clk);
         seen = seen | done;
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_no_done got=%b exp=0", seen); end
      test_walk("after_rst", 0, 2'd0, 1, 2'd1, 2'd3, 2'd0);
   endtask

   initial begin
      test_reset();
      test_walk("single",   0, 2'd2, 1, 2'd2, 2'd3, 2'd2);
      test_walk("two_step", 1, 2'd0, 2, 2'd0, 2'd1, 2'd0);
      test_arb(0, 2'd0);
      test_walk("null_blue", 0, 2'd0, 0, 2'd3, 2'd3, 2'd0);
      test_arb(1, 2'd0);
      test_walk("blue_red",  0, 2'd1, 1, 2'd1, 2'd3, 2'd1);
      test_walk("null_red",  0, 2'd1, 0, 2'd3, 2'd3, 2'd1);
      test_walk("null_inv",  0, 2'd3, 0, 2'd3, 2'd3, 2'd1);
      test_fb_err();
      test_walk("to_blue",   0, 2'd0, 1, 2'd1, 2'd3, 2'd0);
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
